trap_ctrl: RTL and testbench
============================

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter RESET_MTVEC, default 32'h0000_0100, reset value of mtvec.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port timer_irq  input  1  level interrupt from the timer peripheral (mtime >= mtimecmp).
REQ-005 SHALL have port instr_valid  input  1  one instruction commits this cycle.
REQ-006 SHALL have port instr_pc  input  32  PC of the committing instruction.
REQ-007 SHALL have port ecall  input  1  committing instruction is ECALL; qualified by instr_valid.
REQ-008 SHALL have port mret  input  1  committing instruction is MRET; qualified by instr_valid.
REQ-009 SHALL have port csr_op  input  2  00 none, 01 write, 10 set bits, 11 clear bits; qualified by instr_valid.
REQ-010 SHALL have port csr_addr  input  12  CSR address.
REQ-011 SHALL have port csr_wdata  input  32  CSR operand.
REQ-012 SHALL have port csr_rdata  output  32  combinational read of csr_addr; 0 for unimplemented addresses.
REQ-013 SHALL have port redirect  output  1  one-cycle pulse; fetch SHALL jump to redirect_pc.
REQ-014 SHALL have port redirect_pc  output  32  target for redirect; valid while redirect=1.

Function
REQ-015 SHALL implement mstatus 0x300 (MIE bit3, MPIE bit7, other bits read 0), mie 0x304 (MTIE bit7 only), mtvec 0x305 (bits[1:0] read 0, direct mode), mepc 0x341 (bits[1:0] read 0), mcause 0x342 (full 32 bits), mip 0x344 (MTIP bit7, read-only).
REQ-016 SHALL register timer_irq once per cycle into mip.MTIP; writes to mip SHALL be ignored.
REQ-017 SHALL use FSM states RUN and REDIR; RUN->REDIR on trap or MRET acceptance; REDIR->RUN unconditionally after one cycle.
REQ-018 SHALL assert redirect exactly during REDIR, with redirect_pc held registered.
REQ-019 SHALL, in RUN with instr_valid=1 and MIE&MTIE&MTIP=1, take an interrupt: mepc<=instr_pc, mcause<=32'h8000_0007, MPIE<=MIE, MIE<=0, redirect_pc<=mtvec; the committing instruction is discarded.
REQ-020 SHALL otherwise, on ecall in RUN, trap: mepc<=instr_pc, mcause<=32'd11, MPIE<=MIE, MIE<=0, redirect_pc<=mtvec.
REQ-021 SHALL otherwise, on mret in RUN, set MIE<=MPIE, MPIE<=1, redirect_pc<=mepc.
REQ-022 SHALL apply priority interrupt > ecall > mret > CSR op; the CSR op SHALL be discarded whenever a trap or MRET is accepted in that cycle.
REQ-023 SHALL ignore instr_valid and all its qualified inputs during REDIR (pipeline flushing).
REQ-024 SHALL, for csr_op 10/11, compute new = old | wdata and old & ~wdata, then apply the per-register write masks.
REQ-025 SHALL present CSR write results on csr_rdata from the following cycle; the interrupt enable check SHALL use pre-write register values.
REQ-026 SHALL keep an interrupt pending while timer_irq stays high; after MRET re-enables MIE the interrupt SHALL be taken at the next instr_valid.
REQ-027 SHALL not take an interrupt when instr_valid=0, even if enabled and pending.

Reset
REQ-028 SHALL, while rst_n=0, force state RUN, redirect=0, redirect_pc=0, MIE=0, MPIE=0, MTIE=0, MTIP=0, mepc=0, mcause=0, mtvec=RESET_MTVEC.
REQ-029 SHALL discard an in-flight REDIR on reset; after rst_n rises the first edge SHALL operate from RUN.

Structure
REQ-030 SHALL take CSR addresses, bit positions, cause codes, csr_op encodings and the FSM state enum from shared package trap_pkg.
REQ-031 SHALL place the CSR registers, write masking and read mux in one sub-module, trap_csr_regs; the FSM and priority logic SHALL stay in trap_ctrl.

Verification
REQ-032 SHALL cover: reset, then read 0x305 -> 32'h0000_0100; read 0x300 -> 0.
REQ-033 SHALL cover: write mie=0x80 and mstatus=0x8, raise timer_irq, commit pc=0x40 -> next cycle redirect=1 with redirect_pc=0x100; mepc=0x40, mcause=0x8000_0007, mstatus=0x80.
REQ-034 SHALL cover: keep timer_irq=1, then MRET commits -> redirect_pc=0x40 and mstatus=0x88; next committing instruction is trapped again.
REQ-035 SHALL cover: ecall at pc=0x200 with MIE=0 -> redirect_pc=mtvec, mcause=11, mepc=0x200.
REQ-036 SHALL cover: interrupt, ecall and mtvec write in the same cycle -> interrupt taken, mcause=0x8000_0007, mtvec unchanged.
REQ-037 SHALL cover: csr set 0x304 with 0xFFFF_FFFF -> reads 0x80; write 0x305 with 0x123 -> reads 0x120; rst_n low during REDIR -> redirect=0 immediately.

Source files
------------

// File: rtl/trap_pkg.sv
// ============================================================================
// Module  : trap_pkg
// Purpose : Shared CSR addresses, bit positions, cause codes, csr_op
//           encodings and FSM state type for the machine-mode trap controller.
// Rev     : 1.0
// ============================================================================
`default_nettype none

package trap_pkg;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_REDIR = 1'b1
    } state_e;

    localparam logic [11:0] c_ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] c_ADDR_MIE     = 12'h304;
    localparam logic [11:0] c_ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] c_ADDR_MEPC    = 12'h341;
    localparam logic [11:0] c_ADDR_MCAUSE  = 12'h342;
    localparam logic [11:0] c_ADDR_MIP     = 12'h344;

    localparam int c_BIT_MIE  = 3;
    localparam int c_BIT_MPIE = 7;
    localparam int c_BIT_MTIE = 7;
    localparam int c_BIT_MTIP = 7;

    localparam logic [31:0] c_CAUSE_MTI   = 32'h8000_0007;
    localparam logic [31:0] c_CAUSE_ECALL = 32'd11;

    localparam logic [1:0] c_CSR_NONE  = 2'b00;
    localparam logic [1:0] c_CSR_WRITE = 2'b01;
    localparam logic [1:0] c_CSR_SET   = 2'b10;
    localparam logic [1:0] c_CSR_CLR   = 2'b11;

    function automatic logic [31:0] csr_apply(input logic [1:0]  op,
                                              input logic [31:0] old,
                                              input logic [31:0] wdata);
        case (op)
            c_CSR_SET: csr_apply = old | wdata;
            c_CSR_CLR: csr_apply = old & ~wdata;
            default:   csr_apply = wdata;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/trap_csr_regs.sv
// ============================================================================
// Module  : trap_csr_regs
// Purpose : Machine CSR storage, masked read-modify-write and read mux.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module trap_csr_regs
    import trap_pkg::*;
#(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_timer_irq,
    input  logic        i_csr_we,
    input  logic [1:0]  i_csr_op,
    input  logic [11:0] i_csr_addr,
    input  logic [31:0] i_csr_wdata,
    input  logic        i_trap,
    input  logic [31:0] i_trap_cause,
    input  logic [31:0] i_trap_pc,
    input  logic        i_mret,
    output logic [31:0] o_csr_rdata,
    output logic        o_irq_pending,
    output logic [31:0] o_mtvec,
    output logic [31:0] o_mepc
);

    logic        r_mie;
    logic        r_mpie;
    logic        r_mtie;
    logic        r_mtip;
    logic [31:0] r_mtvec;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] w_csr_new;

    always_comb begin
        o_csr_rdata = 32'd0;
        case (i_csr_addr)
            c_ADDR_MSTATUS: begin
                o_csr_rdata[c_BIT_MIE]  = r_mie;
                o_csr_rdata[c_BIT_MPIE] = r_mpie;
            end
            c_ADDR_MIE:    o_csr_rdata[c_BIT_MTIE] = r_mtie;
            c_ADDR_MTVEC:  o_csr_rdata = r_mtvec;
            c_ADDR_MEPC:   o_csr_rdata = r_mepc;
            c_ADDR_MCAUSE: o_csr_rdata = r_mcause;
            c_ADDR_MIP:    o_csr_rdata[c_BIT_MTIP] = r_mtip;
            default:       o_csr_rdata = 32'd0;
        endcase
    end

    // Set/clear operate on the architecturally visible (already masked) value.
    assign w_csr_new     = csr_apply(i_csr_op, o_csr_rdata, i_csr_wdata);
    assign o_irq_pending = r_mie & r_mtie & r_mtip;
    assign o_mtvec       = r_mtvec;
    assign o_mepc        = r_mepc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mie    <= 1'b0;
            r_mpie   <= 1'b0;
            r_mtie   <= 1'b0;
            r_mtip   <= 1'b0;
            r_mtvec  <= {RESET_MTVEC[31:2], 2'b00};
            r_mepc   <= 32'd0;
            r_mcause <= 32'd0;
        end else begin
            r_mtip <= i_timer_irq;
            if (i_trap) begin
                r_mepc   <= {i_trap_pc[31:2], 2'b00};
                r_mcause <= i_trap_cause;
                r_mpie   <= r_mie;
                r_mie    <= 1'b0;
            end else if (i_mret) begin
                r_mie  <= r_mpie;
                r_mpie <= 1'b1;
            end else if (i_csr_we) begin
                case (i_csr_addr)
                    c_ADDR_MSTATUS: begin
                        r_mie  <= w_csr_new[c_BIT_MIE];
                        r_mpie <= w_csr_new[c_BIT_MPIE];
                    end
                    c_ADDR_MIE:    r_mtie   <= w_csr_new[c_BIT_MTIE];
                    c_ADDR_MTVEC:  r_mtvec  <= {w_csr_new[31:2], 2'b00};
                    c_ADDR_MEPC:   r_mepc   <= {w_csr_new[31:2], 2'b00};
                    c_ADDR_MCAUSE: r_mcause <= w_csr_new;
                    default:       ;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/trap_ctrl.sv
// ============================================================================
// Module  : trap_ctrl
// Purpose : Machine-mode trap/return sequencer with timer interrupt, ECALL,
//           MRET and CSR access; issues a one-cycle fetch redirect.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module trap_ctrl
    import trap_pkg::*;
#(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        timer_irq,
    input  logic        instr_valid,
    input  logic [31:0] instr_pc,
    input  logic        ecall,
    input  logic        mret,
    input  logic [1:0]  csr_op,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        redirect,
    output logic [31:0] redirect_pc
);

    state_e      r_state;
    state_e      w_state_nxt;
    logic [31:0] r_redirect_pc;
    logic [31:0] w_redirect_pc_nxt;
    logic        w_irq_pending;
    logic [31:0] w_mtvec;
    logic [31:0] w_mepc;
    logic        w_take_irq;
    logic        w_take_ecall;
    logic        w_take_mret;
    logic        w_csr_we;
    logic        w_trap;
    logic [31:0] w_trap_cause;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_RUN;
            r_redirect_pc <= 32'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_redirect_pc <= w_redirect_pc_nxt;
        end
    end

    // Priority: interrupt > ecall > mret > CSR op; nothing is accepted in REDIR.
    always_comb begin
        w_state_nxt       = r_state;
        w_redirect_pc_nxt = r_redirect_pc;
        w_take_irq        = 1'b0;
        w_take_ecall      = 1'b0;
        w_take_mret       = 1'b0;
        w_csr_we          = 1'b0;
        w_trap_cause      = c_CAUSE_ECALL;
        case (r_state)
            ST_RUN: begin
                if (instr_valid) begin
                    if (w_irq_pending) begin
                        w_take_irq   = 1'b1;
                        w_trap_cause = c_CAUSE_MTI;
                    end else if (ecall) begin
                        w_take_ecall = 1'b1;
                    end else if (mret) begin
                        w_take_mret = 1'b1;
                    end else if (csr_op != c_CSR_NONE) begin
                        w_csr_we = 1'b1;
                    end
                end
            end
            ST_REDIR: w_state_nxt = ST_RUN;
        endcase
        w_trap = w_take_irq | w_take_ecall;
        if (w_trap) begin
            w_state_nxt       = ST_REDIR;
            w_redirect_pc_nxt = w_mtvec;
        end else if (w_take_mret) begin
            w_state_nxt       = ST_REDIR;
            w_redirect_pc_nxt = w_mepc;
        end
    end

    assign redirect    = (r_state == ST_REDIR);
    assign redirect_pc = r_redirect_pc;

    trap_csr_regs #(
        .RESET_MTVEC (RESET_MTVEC)
    ) u_csr_regs (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_timer_irq   (timer_irq),
        .i_csr_we      (w_csr_we),
        .i_csr_op      (csr_op),
        .i_csr_addr    (csr_addr),
        .i_csr_wdata   (csr_wdata),
        .i_trap        (w_trap),
        .i_trap_cause  (w_trap_cause),
        .i_trap_pc     (instr_pc),
        .i_mret        (w_take_mret),
        .o_csr_rdata   (csr_rdata),
        .o_irq_pending (w_irq_pending),
        .o_mtvec       (w_mtvec),
        .o_mepc        (w_mepc)
    );

endmodule

`default_nettype wire

// File: tb/tb_trap_ctrl.sv
// ============================================================================
// Module  : tb_trap_ctrl
// Purpose : Scoreboard bench for trap_ctrl: architectural model predicts
//           redirect targets and CSR contents for directed and random traffic.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        timer_irq = 1'b0;
    logic        instr_valid = 1'b0;
    logic [31:0] instr_pc = 32'd0;
    logic        ecall = 1'b0;
    logic        mret = 1'b0;
    logic [1:0]  csr_op = 2'b00;
    logic [11:0] csr_addr = 12'd0;
    logic [31:0] csr_wdata = 32'd0;
    logic [31:0] csr_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    // Architectural model state
    bit          m_mie, m_mpie, m_mtie, m_mtip, m_redir;
    logic [31:0] m_mepc, m_mcause, m_mtvec;

    trap_ctrl #(.RESET_MTVEC(32'h0000_0100)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .timer_irq   (timer_irq),
        .instr_valid (instr_valid),
        .instr_pc    (instr_pc),
        .ecall       (ecall),
        .mret        (mret),
        .csr_op      (csr_op),
        .csr_addr    (csr_addr),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [11:0] a);
        case (a)
            12'h300: return (m_mie ? 32'h8 : 32'h0) + (m_mpie ? 32'h80 : 32'h0);
            12'h304: return m_mtie ? 32'h80 : 32'h0;
            12'h305: return m_mtvec;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'h344: return m_mtip ? 32'h80 : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_mie = 0; m_mpie = 0; m_mtie = 0; m_mtip = 0; m_redir = 0;
        m_mepc = 0; m_mcause = 0; m_mtvec = 32'h100;
    endtask

    task automatic model_trap(input logic [31:0] cause);
        exp_q.push_back(m_mtvec);
        m_mepc   = instr_pc & ~32'h3;
        m_mcause = cause;
        m_mpie   = m_mie;
        m_mie    = 0;
    endtask

    // Advance one clock; the model consumes whatever is on the inputs now.
    task automatic tick();
        bit          acc;
        logic [31:0] oldv, newv;
        acc = 0;
        if (!rst_n) begin
            model_reset();
        end else if (!m_redir && instr_valid) begin
            if (m_mie && m_mtie && m_mtip) begin
                model_trap(32'h8000_0007); acc = 1;
            end else if (ecall) begin
                model_trap(32'd11); acc = 1;
            end else if (mret) begin
                exp_q.push_back(m_mepc);
                m_mie  = m_mpie;
                m_mpie = 1;
                acc    = 1;
            end else if (csr_op != 2'b00) begin
                oldv = mread(csr_addr);
                newv = (csr_op == 2'b01) ? csr_wdata :
                       (csr_op == 2'b10) ? (oldv | csr_wdata) : (oldv & ~csr_wdata);
                case (csr_addr)
                    12'h300: begin m_mie = newv[3]; m_mpie = newv[7]; end
                    12'h304: m_mtie = newv[7];
                    12'h305: m_mtvec = newv & ~32'h3;
                    12'h341: m_mepc = newv & ~32'h3;
                    12'h342: m_mcause = newv;
                    default: ;
                endcase
            end
        end
        if (rst_n) begin
            m_redir = acc;
            m_mtip  = timer_irq;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] pc, input bit ec, input bit mr,
                         input logic [1:0] op, input logic [11:0] a, input logic [31:0] wd);
        instr_valid = v; instr_pc = pc; ecall = ec; mret = mr;
        csr_op = op; csr_addr = a; csr_wdata = wd;
    endtask

    task automatic idle();
        drive(0, 32'h0, 0, 0, 2'b00, 12'h0, 32'h0);
        tick();
    endtask

    task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
        drive(0, 32'h0, 0, 0, 2'b00, a, 32'h0);
        #1;
        check(name, csr_rdata, exp);
    endtask

    // Monitor: every redirect pulse must match the next predicted target.
    always @(negedge clk) begin
        if (rst_n && redirect) begin
            if (exp_q.size() == 0)
                check("redir_unexpected", {31'b0, redirect}, 32'd0);
            else
                check("redirect_pc", redirect_pc, exp_q.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] addrs [8];
        addrs = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344, 12'h000, 12'h7FF};
        model_reset();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_redirect", {31'b0, redirect}, 32'd0);
        check("rst_redirect_pc", redirect_pc, 32'd0);
        rst_n = 1;
        rd("rst_mtvec", 12'h305, 32'h100);
        rd("rst_mstatus", 12'h300, 32'h0);

        // Timer interrupt taken at a commit
        drive(1, 32'h30, 0, 0, 2'b01, 12'h304, 32'h80); tick();
        drive(1, 32'h34, 0, 0, 2'b01, 12'h300, 32'h8);  tick();
        timer_irq = 1;
        idle();
        idle();
        rd("no_irq_without_valid", 12'h341, 32'h0);
        drive(1, 32'h40, 0, 0, 2'b00, 12'h0, 32'h0); tick();
        check("irq_redirect", {31'b0, redirect}, 32'd1);
        // Writes during REDIR must be dropped
        drive(1, 32'h44, 0, 0, 2'b01, 12'h342, 32'hDEAD); tick();
        rd("irq_mepc", 12'h341, 32'h40);
        rd("irq_mcause", 12'h342, 32'h8000_0007);
        rd("irq_mstatus", 12'h300, 32'h80);

        // MRET re-enables, pending interrupt re-taken next commit
        drive(1, 32'h44, 0, 1, 2'b00, 12'h0, 32'h0); tick();
        idle();
        rd("mret_mstatus", 12'h300, 32'h88);
        drive(1, 32'h48, 0, 0, 2'b00, 12'h0, 32'h0); tick();
        idle();
        rd("retrap_mepc", 12'h341, 32'h48);
        timer_irq = 0;
        idle();

        // ECALL with MIE=0
        drive(1, 32'h200, 1, 0, 2'b00, 12'h0, 32'h0); tick();
        idle();
        rd("ecall_mcause", 12'h342, 32'd11);
        rd("ecall_mepc", 12'h341, 32'h200);

        // Interrupt + ecall + mtvec write together
        drive(1, 32'h50, 0, 0, 2'b01, 12'h300, 32'h8); tick();
        timer_irq = 1;
        idle();
        drive(1, 32'h300, 1, 0, 2'b01, 12'h305, 32'h400); tick();
        idle();
        rd("combo_mcause", 12'h342, 32'h8000_0007);
        rd("combo_mtvec", 12'h305, 32'h100);
        timer_irq = 0;
        idle();

        // Masking
        drive(1, 32'h60, 0, 0, 2'b10, 12'h304, 32'hFFFF_FFFF); tick();
        rd("set_mie", 12'h304, 32'h80);
        drive(1, 32'h64, 0, 0, 2'b01, 12'h305, 32'h123); tick();
        rd("mtvec_mask", 12'h305, 32'h120);
        drive(1, 32'h68, 0, 0, 2'b11, 12'h304, 32'h80); tick();
        rd("clr_mie", 12'h304, 32'h0);
        drive(1, 32'h6C, 0, 0, 2'b01, 12'h344, 32'hFFFF_FFFF); tick();
        rd("mip_readonly", 12'h344, 32'h0);

        // Reset during REDIR
        drive(1, 32'h10, 1, 0, 2'b00, 12'h0, 32'h0); tick();
        check("redir_before_rst", {31'b0, redirect}, 32'd1);
        rst_n = 0;
        #1;
        check("rst_in_redir", {31'b0, redirect}, 32'd0);
        check("rst_in_redir_pc", redirect_pc, 32'd0);
        exp_q.delete();
        model_reset();
        rd("rst_mtvec2", 12'h305, 32'h100);
        idle();
        rst_n = 1;
        drive(1, 32'h80, 1, 0, 2'b00, 12'h0, 32'h0); tick();
        check("run_after_rst", {31'b0, redirect}, 32'd1);
        idle();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) timer_irq = ~timer_irq;
            drive($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 19) == 0, 2'($urandom_range(0, 3)),
                  addrs[$urandom_range(0, 7)], $urandom);
            #1;
            check("rand_rdata", csr_rdata, mread(csr_addr));
            tick();
        end

        timer_irq = 0;
        repeat (3) idle();
        check("redir_drain", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
